// File: rtl/sha256d_sweep_core.sv
// sha256d_sweep_core: iterative double-SHA-256 nonce sweep over an 80-byte header.
// Define SHA256D_MIDSTATE_EN to compress the first header block once per sweep and reuse its midstate.
module sha256d_sweep_core #(
  parameter int ROUNDS_PER_CLK = 1,
  parameter int NONCE_W        = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [639:0]       header,
  input  logic [NONCE_W-1:0] nonceStart,
  input  logic [NONCE_W-1:0] nonceEnd,
  input  logic [255:0]       target,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [NONCE_W-1:0] foundNonce,
  output logic [255:0]       digest,
  output logic [2:0]         state_dbg
);

  // Handshake: start is accepted only while busy=0 and latches all inputs; abort is honoured
  // only while busy=1 and never over a result; done pulses one cycle with found/foundNonce/digest valid.

  localparam int                C        = 2 + 64 / ROUNDS_PER_CLK;
  localparam logic [6:0]        CNT_LAST = 7'(C - 1);
  localparam logic [5:0]        RSTEP    = 6'(ROUNDS_PER_CLK);
  localparam logic [NONCE_W-1:0] NONCE_ONE = NONCE_W'(1);
  localparam logic [127:0]      NONCE_MASK = {{(128-NONCE_W){1'b0}}, {NONCE_W{1'b1}}};

  localparam logic [7:0][31:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  // K[0] sits in the top word, so round t reads index 63-t.
  localparam logic [63:0][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
`ifdef SHA256D_MIDSTATE_EN
    S_PRE  = 3'd1,
`else
    S_H1B1 = 3'd2,
`endif
    S_H1B2 = 3'd3,
    S_H2   = 3'd4,
    S_CMP  = 3'd5,
    S_DONE = 3'd6
  } state_t;

`ifdef SHA256D_MIDSTATE_EN
  localparam state_t S_FIRST = S_PRE;
  localparam state_t S_LOOP  = S_H1B2;
`else
  localparam state_t S_FIRST = S_H1B1;
  localparam state_t S_LOOP  = S_H1B1;
`endif

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Working vars are kept a..h at indices 7..0 so the packed vector reads like H0..H7.
  function automatic logic [7:0][31:0] sha_round(input logic [7:0][31:0] s,
                                                 input logic [31:0] k, input logic [31:0] w);
    logic [31:0] t1;
    logic [31:0] t2;
    t1 = s[0] + bsig1(s[3]) + ((s[3] & s[2]) ^ (~s[3] & s[1])) + k + w;
    t2 = bsig0(s[7]) + ((s[7] & s[6]) ^ (s[7] & s[5]) ^ (s[6] & s[5]));
    return {t1 + t2, s[7], s[6], s[5], s[4] + t1, s[3], s[2], s[1]};
  endfunction

  // Window holds W[t] at index 15 down to W[t+15] at index 0.
  function automatic logic [15:0][31:0] sched(input logic [15:0][31:0] w);
    logic [31:0] nw;
    nw = ssig1(w[1]) + w[6] + ssig0(w[14]) + w[15];
    return {w[14:0], nw};
  endfunction

  state_t               state_q, state_d;
  logic [6:0]           cnt_q;
  logic [5:0]           rnd_q;
  logic [7:0][31:0]     st_q;
  logic [7:0][31:0]     cv_q;
  logic [15:0][31:0]    w_q;
  logic [639:0]         hdr_q;
  logic [NONCE_W-1:0]   nonce_q;
  logic [NONCE_W-1:0]   end_q;
  logic [255:0]         tgt_q;
`ifdef SHA256D_MIDSTATE_EN
  logic [7:0][31:0]     mid_q;
`endif

  logic                 in_comp;
  logic                 phase_last;
  logic                 accept;
  logic                 cmp_pass;
  logic                 last_nonce;
  logic [7:0][31:0]     chain_sel;
  logic [15:0][31:0]    msg_sel;
  logic [7:0][31:0]     cv_sum;
  logic [255:0]         cv_flat;
  logic [255:0]         cv_rev;
  logic [127:0]         blk2_lo;
  logic [7:0][31:0]     st_chain [ROUNDS_PER_CLK+1];
  logic [15:0][31:0]    w_chain  [ROUNDS_PER_CLK+1];

`ifdef SHA256D_MIDSTATE_EN
  assign in_comp = (state_q == S_PRE) || (state_q == S_H1B2) || (state_q == S_H2);
`else
  assign in_comp = (state_q == S_H1B1) || (state_q == S_H1B2) || (state_q == S_H2);
`endif
  assign phase_last = (cnt_q == CNT_LAST);
  assign accept     = (state_q == S_IDLE) && start;
  assign cv_flat    = cv_q;
  assign blk2_lo    = (hdr_q[127:0] & ~NONCE_MASK) | {{(128-NONCE_W){1'b0}}, nonce_q};
  assign cmp_pass   = (cv_rev <= tgt_q);
  assign last_nonce = (nonce_q == end_q);

  // Unrolled round datapath: ROUNDS_PER_CLK rounds and schedule steps per cycle.
  always_comb begin
    st_chain[0] = st_q;
    w_chain[0]  = w_q;
    for (int r = 0; r < ROUNDS_PER_CLK; r++) begin
      st_chain[r+1] = sha_round(st_chain[r], K[6'd63 - (rnd_q + 6'(r))], w_chain[r][15]);
      w_chain[r+1]  = sched(w_chain[r]);
    end
  end

  always_comb begin
    chain_sel = IV;
    msg_sel   = hdr_q[639:128];
    case (state_q)
      S_H1B2: begin
`ifdef SHA256D_MIDSTATE_EN
        chain_sel = mid_q;
`else
        chain_sel = cv_q;
`endif
        msg_sel = {blk2_lo, 32'h8000_0000, 288'd0, 64'd640};
      end
      S_H2:    msg_sel = {cv_flat, 32'h8000_0000, 160'd0, 64'd256};
      default: ;
    endcase
  end

  // Digest byte 0 becomes the least significant byte of the compared value.
  always_comb begin
    cv_sum = '0;
    cv_rev = '0;
    for (int i = 0; i < 8; i++) cv_sum[i] = cv_q[i] + st_q[i];
    for (int i = 0; i < 32; i++) cv_rev[8*i +: 8] = cv_flat[255-8*i -: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_FIRST;
`ifdef SHA256D_MIDSTATE_EN
      S_PRE:  if (phase_last) state_d = S_H1B2;
`else
      S_H1B1: if (phase_last) state_d = S_H1B2;
`endif
      S_H1B2: if (phase_last) state_d = S_H2;
      S_H2:   if (phase_last) state_d = S_CMP;
      S_CMP:  state_d = (cmp_pass || last_nonce) ? S_DONE : S_LOOP;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE) && (state_q != S_DONE) && (state_d != S_DONE))
      state_d = S_IDLE;
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    state_dbg = state_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      rnd_q      <= '0;
      st_q       <= '0;
      cv_q       <= '0;
      w_q        <= '0;
      hdr_q      <= '0;
      nonce_q    <= '0;
      end_q      <= '0;
      tgt_q      <= '0;
      found      <= 1'b0;
      foundNonce <= '0;
      digest     <= '0;
`ifdef SHA256D_MIDSTATE_EN
      mid_q      <= '0;
`endif
    end else begin
      cnt_q <= (in_comp && !phase_last) ? cnt_q + 7'd1 : 7'd0;
      if (accept) begin
        hdr_q      <= header;
        nonce_q    <= nonceStart;
        end_q      <= nonceEnd;
        tgt_q      <= target;
        found      <= 1'b0;
        foundNonce <= '0;
        digest     <= '0;
      end
      if (in_comp) begin
        if (cnt_q == 7'd0) begin
          w_q   <= msg_sel;
          st_q  <= chain_sel;
          cv_q  <= chain_sel;
          rnd_q <= '0;
        end else if (phase_last) begin
          cv_q <= cv_sum;
`ifdef SHA256D_MIDSTATE_EN
          if (state_q == S_PRE) mid_q <= cv_sum;
`endif
        end else begin
          st_q  <= st_chain[ROUNDS_PER_CLK];
          w_q   <= w_chain[ROUNDS_PER_CLK];
          rnd_q <= rnd_q + RSTEP;
        end
      end
      if (state_q == S_CMP) begin
        if (cmp_pass) begin
          found      <= 1'b1;
          foundNonce <= nonce_q;
          digest     <= cv_flat;
        end else if (!last_nonce) begin
          nonce_q <= nonce_q + NONCE_ONE;
        end
      end
    end
  end

endmodule
